// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the dual-slot memory port arbiter: FSM states, stall encoding,
// and the per-slot request bundle.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WEN_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } arb_state_t;

    typedef enum logic {
        NO_STOP = 1'b0,
        STOP    = 1'b1
    } stall_t;

    typedef struct packed {
        logic              en;
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '0;

    function automatic logic is_load(input mem_req_t r);
        return r.en && (r.wen == '0);
    endfunction

endpackage

// File: rtl/mem_req_mux.sv
// 2:1 selector for a complete slot request (en/wen/addr/wdata); sel=0 picks req_a.
module mem_req_mux
    import mem_port_arbiter_pkg::*;
(
    input  logic     sel,
    input  mem_req_t req_a,
    input  mem_req_t req_b,
    output mem_req_t req_out
);

    assign req_out = sel ? req_b : req_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read SRAM port between two issue slots. A dual-op pair is
// split over two cycles (older first); load results of a pair are returned together.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              older_sel,
    input  logic              req1_en,
    input  logic              req2_en,
    input  logic [WEN_W-1:0]  req1_wen,
    input  logic [WEN_W-1:0]  req2_wen,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              data_sram_en,
    output logic [WEN_W-1:0]  data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              stallreq_for_mem,
    output logic [DATA_W-1:0] ld_data1,
    output logic [DATA_W-1:0] ld_data2,
    output logic              ld_valid1,
    output logic              ld_valid2
);

    arb_state_t        state;
    mem_req_t          req1, req2, first_req, young_req, lat_req, issue_req;
    logic              lat_slot;
    logic              both, first_slot, issue_slot;
    logic              frozen, active, issue_go, ret_load;
    logic              ret_valid, ret_slot, ret_to_buf, pair_done;
    logic              buf_valid, buf_slot;
    logic [DATA_W-1:0] buf_data;

    assign req1 = {req1_en, req1_wen, req1_addr, req1_wdata};
    assign req2 = {req2_en, req2_wen, req2_addr, req2_wdata};
    assign both = req1_en && req2_en;

    // Slot id 0 = slot1, 1 = slot2. With a single request the lone slot wins.
    assign first_slot = both ? older_sel : (req2_en && !req1_en);

    mem_req_mux u_first_mux (
        .sel     (first_slot),
        .req_a   (req1),
        .req_b   (req2),
        .req_out (first_req)
    );

    mem_req_mux u_young_mux (
        .sel     (~older_sel),
        .req_a   (req1),
        .req_b   (req2),
        .req_out (young_req)
    );

    assign frozen     = (stall_t'(hold) == STOP);
    assign active     = !rst && !flush && !frozen;
    assign issue_req  = (state == SECOND) ? lat_req : first_req;
    assign issue_slot = (state == SECOND) ? lat_slot : first_slot;
    assign issue_go   = active && issue_req.en;
    assign ret_load   = active && is_load(issue_req);

    assign data_sram_en    = issue_go;
    assign data_sram_wen   = issue_go ? issue_req.wen   : '0;
    assign data_sram_addr  = issue_go ? issue_req.addr  : '0;
    assign data_sram_wdata = issue_go ? issue_req.wdata : '0;

    // While frozen, a pending younger op still needs ID/EX held.
    assign stallreq_for_mem = !rst && !flush &&
                              (frozen ? (state == SECOND) : (state == IDLE && both));

    always_comb begin
        ld_valid1 = 1'b0;
        ld_valid2 = 1'b0;
        ld_data1  = '0;
        ld_data2  = '0;
        if (!rst) begin
            if (ret_valid && !ret_to_buf) begin
                if (ret_slot) begin
                    ld_valid2 = 1'b1;
                    ld_data2  = data_sram_rdata;
                end else begin
                    ld_valid1 = 1'b1;
                    ld_data1  = data_sram_rdata;
                end
            end
            if (pair_done && buf_valid) begin
                if (buf_slot) begin
                    ld_valid2 = 1'b1;
                    ld_data2  = buf_data;
                end else begin
                    ld_valid1 = 1'b1;
                    ld_data1  = buf_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= IDLE;
            lat_req    <= REQ_NONE;
            lat_slot   <= 1'b0;
            ret_valid  <= 1'b0;
            ret_slot   <= 1'b0;
            ret_to_buf <= 1'b0;
            pair_done  <= 1'b0;
            buf_valid  <= 1'b0;
            buf_slot   <= 1'b0;
            buf_data   <= '0;
        end else begin
            ret_valid  <= ret_load;
            ret_slot   <= issue_slot;
            ret_to_buf <= issue_go && (state == IDLE) && both;
            pair_done  <= issue_go && (state == SECOND);
            if (pair_done) begin
                buf_valid <= 1'b0;
                buf_slot  <= 1'b0;
                buf_data  <= '0;
            end
            // Older load of a split pair: park its data until the younger returns.
            if (ret_valid && ret_to_buf) begin
                buf_valid <= 1'b1;
                buf_slot  <= ret_slot;
                buf_data  <= data_sram_rdata;
            end
            if (!frozen) begin
                case (state)
                    IDLE: begin
                        if (both) begin
                            state    <= SECOND;
                            lat_req  <= young_req;
                            lat_slot <= ~older_sel;
                        end
                    end
                    SECOND: begin
                        state    <= IDLE;
                        lat_req  <= REQ_NONE;
                        lat_slot <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
